// File: rtl/parity_frame_tx.sv
// Serial byte transmitter: START, 8 DATA bits (LSB first), PARITY, STOP, each held CLKS_PER_BIT cycles.
// Optional macro PARITY_TX_ODD_SEL_EN adds a parity_odd input that selects odd parity per byte.
module parity_frame_tx #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef PARITY_TX_ODD_SEL_EN
  input  logic       parity_odd,
`endif
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       parity_out,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  localparam logic [7:0] CNT_MAX = 8'(CLKS_PER_BIT - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] data_q, data_d;
  logic       parity_q, parity_d;
  logic       bit_last;
  logic       odd_sel;

`ifdef PARITY_TX_ODD_SEL_EN
  assign odd_sel = parity_odd;
`else
  assign odd_sel = 1'b0;
`endif

  assign bit_last = (cnt_q == CNT_MAX);

  // NOTE: reset lives inside the clocked block, so it only takes effect on a rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      parity_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      parity_q  <= parity_d;
    end
  end

  always_comb begin
    // NOTE: hold-value defaults first, so no path through the case infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    parity_d  = parity_q;
    if (state_q == S_IDLE) begin
      cnt_d     = '0;
      bit_idx_d = '0;
      if (in_valid) begin
        data_d   = in_data;
        parity_d = (^in_data) ^ odd_sel;
        state_d  = S_START;
      end
    end else if (!bit_last) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = '0;
      unique case (state_q)
        S_START:  state_d = S_DATA;
        S_DATA: begin
          if (bit_idx_q == 3'd7) state_d = S_PARITY;
          else bit_idx_d = bit_idx_q + 3'd1;
        end
        S_PARITY: state_d = S_STOP;
        S_STOP:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Outputs decode the registered state; the start bit appears the cycle after acceptance.
  always_comb begin
    tx         = 1'b1;
    busy       = (state_q != S_IDLE);
    in_ready   = (state_q == S_IDLE) && rst_n;
    frame_done = (state_q == S_STOP) && bit_last;
    parity_out = parity_q;
    unique case (state_q)
      S_START:  tx = 1'b0;
      S_DATA:   tx = data_q[bit_idx_q];
      S_PARITY: tx = parity_q;
      default:  tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Self-checking bench for parity_frame_tx: scoreboard of expected frames, CLKS_PER_BIT=4 and =1 instances.
module tb_parity_frame_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       parity_odd = 1'b0;
  logic       in_ready, tx, busy, parity_out, frame_done;

  logic [7:0] in_data1 = 8'h00;
  logic       in_valid1 = 1'b0;
  logic       in_ready1, tx1, busy1, parity_out1, frame_done1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  data;
    logic        par;
    logic [10:0] bits;
  } frame_t;

  frame_t sb[$];

  always #5 clk = ~clk;

  parity_frame_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef PARITY_TX_ODD_SEL_EN
    .parity_odd (parity_odd),
`endif
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .parity_out (parity_out),
    .frame_done (frame_done)
  );

  parity_frame_tx #(.CLKS_PER_BIT(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef PARITY_TX_ODD_SEL_EN
    .parity_odd (1'b0),
`endif
    .in_data    (in_data1),
    .in_valid   (in_valid1),
    .in_ready   (in_ready1),
    .tx         (tx1),
    .busy       (busy1),
    .parity_out (parity_out1),
    .frame_done (frame_done1)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic frame_t model(input logic [7:0] d, input logic odd);
    frame_t f;
    f.data    = d;
    f.par     = (^d) ^ odd;
    f.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) f.bits[1+i] = d[i];
    f.bits[9]  = f.par;
    f.bits[10] = 1'b1;
    return f;
  endfunction

  // Waits (bounded) for in_ready, offers a byte for one edge, pushes its expected frame.
  task automatic accept(input logic [7:0] d, input logic odd, input logic hold);
    int   n = 0;
    logic odd_eff;
`ifdef PARITY_TX_ODD_SEL_EN
    odd_eff = odd;
`else
    odd_eff = 1'b0;
`endif
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_wait data=%h in_ready=%b expected 1", d, in_ready);
    end
    in_data    = d;
    in_valid   = 1'b1;
    parity_odd = odd;
    sb.push_back(model(d, odd_eff));
    @(posedge clk);
    #1;
    parity_odd = ~odd;
    if (hold) in_data = 8'hFF;
    else in_valid = 1'b0;
  endtask

  // Pops one expected frame and compares every cycle of it, starting the cycle after acceptance.
  task automatic check_frame();
    frame_t f;
    logic   exp_tx;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty size=0 expected >0");
      return;
    end
    f = sb.pop_front();
    for (int k = 1; k <= 11 * CPB; k++) begin
      @(negedge clk);
      exp_tx = f.bits[(k - 1) / CPB];
      checks += 4;
      if (tx !== exp_tx) begin
        failures++;
        $display("FAIL tx data=%h cycle=%0d got=%b expected=%b", f.data, k, tx, exp_tx);
      end
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL busy data=%h cycle=%0d got=%b expected=1", f.data, k, busy);
      end
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL in_ready_busy data=%h cycle=%0d got=%b expected=0", f.data, k, in_ready);
      end
      if (frame_done !== (k == 11 * CPB)) begin
        failures++;
        $display("FAIL frame_done data=%h cycle=%0d got=%b expected=%b", f.data, k, frame_done,
                 (k == 11 * CPB));
      end
      if (k == 1) begin
        checks++;
        if (parity_out !== f.par) begin
          failures++;
          $display("FAIL parity_out data=%h got=%b expected=%b", f.data, parity_out, f.par);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_valid1 = 1'b0;
    repeat (2) @(negedge clk);
    checks += 5;
    if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b expected=1", tx); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b expected=0", busy); end
    if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b expected=0", frame_done); end
    if (parity_out !== 1'b0) begin failures++; $display("FAIL reset_parity_out got=%b expected=0", parity_out); end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b expected=0", in_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b expected=1", in_ready); end
  endtask

  task automatic test_basic();
    accept(8'h02, 1'b0, 1'b0);
    check_frame();
  endtask

  task automatic test_parity_seq();
    logic [7:0] vals [3] = '{8'h03, 8'h08, 8'h0F};
    foreach (vals[i]) begin
      accept(vals[i], 1'b0, 1'b0);
      check_frame();
    end
  endtask

  task automatic test_back_to_back();
    accept(8'h02, 1'b0, 1'b1);
    check_frame();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first_idle_ready got=%b expected=1", in_ready);
    end
    sb.push_back(model(8'hFF, 1'b0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_frame();
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL b2b_no_queue busy=%b expected=0", busy); end
  endtask

  task automatic test_reset_mid();
    frame_t f;
    accept(8'h57, 1'b0, 1'b0);
    f = sb.pop_front();
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      checks++;
      if (tx !== f.bits[(k - 1) / CPB]) begin
        failures++;
        $display("FAIL mid_tx cycle=%0d got=%b expected=%b", k, tx, f.bits[(k - 1) / CPB]);
      end
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks += 5;
    if (tx !== 1'b1) begin failures++; $display("FAIL abort_tx got=%b expected=1", tx); end
    if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b expected=0", busy); end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL abort_in_ready got=%b expected=0", in_ready); end
    if (parity_out !== 1'b0) begin failures++; $display("FAIL abort_parity_out got=%b expected=0", parity_out); end
    if (frame_done !== 1'b0) begin failures++; $display("FAIL abort_frame_done got=%b expected=0", frame_done); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b expected=1", in_ready); end
    accept(8'h0F, 1'b0, 1'b0);
    check_frame();
  endtask

`ifdef PARITY_TX_ODD_SEL_EN
  task automatic test_odd();
    accept(8'h03, 1'b1, 1'b0);
    check_frame();
    accept(8'h02, 1'b1, 1'b0);
    check_frame();
  endtask
`endif

  task automatic test_cpb1();
    frame_t f;
    int     n = 0;
    while (in_ready1 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    f = model(8'h08, 1'b0);
    in_data1  = 8'h08;
    in_valid1 = 1'b1;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    in_data1  = 8'hFF;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      checks += 3;
      if (tx1 !== f.bits[k-1]) begin
        failures++;
        $display("FAIL cpb1_tx cycle=%0d got=%b expected=%b", k, tx1, f.bits[k-1]);
      end
      if (busy1 !== 1'b1) begin failures++; $display("FAIL cpb1_busy cycle=%0d got=%b expected=1", k, busy1); end
      if (frame_done1 !== (k == 11)) begin
        failures++;
        $display("FAIL cpb1_frame_done cycle=%0d got=%b expected=%b", k, frame_done1, (k == 11));
      end
    end
    @(negedge clk);
    checks += 3;
    if (busy1 !== 1'b0) begin failures++; $display("FAIL cpb1_idle_busy got=%b expected=0", busy1); end
    if (in_ready1 !== 1'b1) begin failures++; $display("FAIL cpb1_idle_ready got=%b expected=1", in_ready1); end
    if (parity_out1 !== 1'b1) begin failures++; $display("FAIL cpb1_parity got=%b expected=1", parity_out1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_seq();
    test_back_to_back();
    test_reset_mid();
`ifdef PARITY_TX_ODD_SEL_EN
    test_odd();
`endif
    test_cpb1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
